// File: rtl/dot_pkg.sv
// Shared types and constants for the dot-product accumulator and its lane helpers.
package dot_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    REPORT = 2'd2
  } acc_state_t;

  localparam int LANE_W   = 4;
  localparam int PROD_MAX = 225;

endpackage

// File: rtl/lane_popcount.sv
// Combinational population count of the per-lane pulse vector.
module lane_popcount #(
  parameter  int NUM_LANES = 4,
  localparam int CW        = $clog2(NUM_LANES + 1)
) (
  input  logic [NUM_LANES-1:0] bits,
  output logic [CW-1:0]        count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/dot_accumulator.sv
// Counts unary product pulses from all lanes into one saturating sum and reports it
// once every lane is done (or the cycle budget runs out), with a threshold fire flag.
module dot_accumulator
  import dot_pkg::*;
#(
  parameter int NUM_LANES = 4,
  parameter int SUM_W     = $clog2(NUM_LANES * PROD_MAX + 1),
  parameter int TIMEOUT   = 1023
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [NUM_LANES-1:0] prod_out,
  input  logic [NUM_LANES-1:0] prod_done,
  input  logic [SUM_W-1:0]     threshold,
  output logic [SUM_W-1:0]     sum,
  output logic                 sum_valid,
  output logic                 fire,
  output logic                 timed_out,
  output logic                 busy
);

  localparam int CW    = $clog2(NUM_LANES + 1);
  localparam int SW1   = SUM_W + 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [SUM_W:0]   SUM_MAX  = {1'b0, {SUM_W{1'b1}}};

  acc_state_t           state_reg;
  logic [NUM_LANES-1:0] mask_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic [SUM_W-1:0]     thr_reg;

  logic [NUM_LANES-1:0] live_pulses;
  logic [CW-1:0]        pulse_count;
  logic [SUM_W:0]       sum_wide;
  logic [SUM_W-1:0]     sum_next;
  logic                 done_all;
  logic                 timeout_hit;

  // Lanes already marked done contribute nothing; a lane's first done cycle still counts.
  assign live_pulses = prod_out & ~mask_reg;

  lane_popcount #(.NUM_LANES(NUM_LANES)) u_pop (
    .bits  (live_pulses),
    .count (pulse_count)
  );

  assign sum_wide    = {1'b0, sum} + SW1'(pulse_count);
  assign sum_next    = (sum_wide > SUM_MAX) ? {SUM_W{1'b1}} : sum_wide[SUM_W-1:0];
  assign done_all    = &(mask_reg | prod_done);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_reg == CNT_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      sum       <= '0;
      sum_valid <= 1'b0;
      fire      <= 1'b0;
      timed_out <= 1'b0;
      busy      <= 1'b0;
      mask_reg  <= '0;
      cnt_reg   <= '0;
      thr_reg   <= '0;
    end else begin
      sum_valid <= 1'b0;
      fire      <= 1'b0;
      timed_out <= 1'b0;
      // start wins in every state; in REPORT the registered report is already on the outputs.
      if (start) begin
        state_reg <= ACCUM;
        busy      <= 1'b1;
        sum       <= '0;
        mask_reg  <= '0;
        cnt_reg   <= '0;
        thr_reg   <= threshold;
      end else begin
        case (state_reg)
          IDLE: begin
            busy <= 1'b0;
          end
          ACCUM: begin
            sum      <= sum_next;
            mask_reg <= mask_reg | prod_done;
            if (TIMEOUT != 0) begin
              cnt_reg <= cnt_reg + CNT_W'(1);
            end
            if (done_all || timeout_hit) begin
              state_reg <= REPORT;
              busy      <= 1'b0;
              sum_valid <= 1'b1;
              fire      <= (sum_next >= thr_reg);
              timed_out <= !done_all;
            end
          end
          REPORT: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
          default: begin
            state_reg <= IDLE;
            busy      <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dot_accumulator.sv
// Directed bench: table of two-lane transactions plus hand sequences for reset,
// restart, back-to-back start and saturation on a narrow four-lane instance.
module tb_dot_accumulator;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  // Two-lane instance with a short timeout
  logic       m_start = 1'b0;
  logic [1:0] m_out = '0, m_done = '0;
  logic [9:0] m_thr = '0, m_sum;
  logic       m_sum_valid, m_fire, m_timed_out, m_busy;

  dot_accumulator #(.NUM_LANES(2), .SUM_W(10), .TIMEOUT(16)) u_main (
    .clk(clk), .reset_n(reset_n), .start(m_start), .prod_out(m_out), .prod_done(m_done),
    .threshold(m_thr), .sum(m_sum), .sum_valid(m_sum_valid), .fire(m_fire),
    .timed_out(m_timed_out), .busy(m_busy)
  );

  // Four-lane narrow instance, timeout disabled
  logic       s_start = 1'b0;
  logic [3:0] s_out = '0, s_done = '0;
  logic [3:0] s_thr = '0, s_sum;
  logic       s_sum_valid, s_fire, s_timed_out, s_busy;

  dot_accumulator #(.NUM_LANES(4), .SUM_W(4), .TIMEOUT(0)) u_sat (
    .clk(clk), .reset_n(reset_n), .start(s_start), .prod_out(s_out), .prod_done(s_done),
    .threshold(s_thr), .sum(s_sum), .sum_valid(s_sum_valid), .fire(s_fire),
    .timed_out(s_timed_out), .busy(s_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Lane i pulses on ACCUM cycles 0..p-1 and holds done from cycle d on.
  // Returns the ACCUM cycle after whose edge sum_valid was seen, or -1.
  task automatic run_body(input int p0, input int d0, input int p1, input int d1, output int lat);
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      m_out[0]  = (c < p0);
      m_out[1]  = (c < p1);
      m_done[0] = (c >= d0);
      m_done[1] = (c >= d1);
      @(posedge clk); #1;
      if (m_sum_valid) begin
        lat = c;
        break;
      end
    end
    m_out  = '0;
    m_done = '0;
  endtask

  task automatic m_issue_start(input int thr);
    m_thr   = 10'(thr);
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
  endtask

  typedef struct {
    int p0, d0, p1, d1, thr;
    int exp_sum, exp_fire, exp_to, exp_lat;
  } vec_t;

  localparam int NEVER = 1000;
  vec_t vecs[8];

  initial begin
    int lat, seen;

    vecs[0] = '{p0: 6, d0: 5,     p1: 15, d1: 14,    thr: 20, exp_sum: 21, exp_fire: 1, exp_to: 0, exp_lat: 14};
    vecs[1] = '{p0: 9, d0: 5,     p1: 0,  d1: 10,    thr: 7,  exp_sum: 6,  exp_fire: 0, exp_to: 0, exp_lat: 10};
    vecs[2] = '{p0: 3, d0: 2,     p1: 2,  d1: NEVER, thr: 5,  exp_sum: 5,  exp_fire: 1, exp_to: 1, exp_lat: 15};
    vecs[3] = '{p0: 0, d0: 0,     p1: 1,  d1: 0,     thr: 0,  exp_sum: 1,  exp_fire: 1, exp_to: 0, exp_lat: 0};
    vecs[4] = '{p0: 0, d0: 3,     p1: 0,  d1: 1,     thr: 1,  exp_sum: 0,  exp_fire: 0, exp_to: 0, exp_lat: 3};
    vecs[5] = '{p0: 20, d0: NEVER, p1: 20, d1: NEVER, thr: 32, exp_sum: 32, exp_fire: 1, exp_to: 1, exp_lat: 15};
    vecs[6] = '{p0: 4, d0: 4,     p1: 4,  d1: 3,     thr: 9,  exp_sum: 8,  exp_fire: 0, exp_to: 0, exp_lat: 4};
    vecs[7] = '{p0: 3, d0: NEVER, p1: 3,  d1: NEVER, thr: 7,  exp_sum: 6,  exp_fire: 0, exp_to: 1, exp_lat: 15};

    repeat (2) @(posedge clk);
    #1;
    check("reset_sum", int'(m_sum), 0);
    check("reset_busy", int'(m_busy), 0);
    check("reset_valid", int'(m_sum_valid), 0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven transactions
    for (int i = 0; i < 8; i++) begin
      m_issue_start(vecs[i].thr);
      check($sformatf("v%0d_busy", i), int'(m_busy), 1);
      run_body(vecs[i].p0, vecs[i].d0, vecs[i].p1, vecs[i].d1, lat);
      $display("txn %0d: sum=%0d fire=%0d timed_out=%0d latency=%0d", i, m_sum, m_fire, m_timed_out, lat);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_sum", i), int'(m_sum), vecs[i].exp_sum);
      check($sformatf("v%0d_fire", i), int'(m_fire), vecs[i].exp_fire);
      check($sformatf("v%0d_to", i), int'(m_timed_out), vecs[i].exp_to);
      // Lane activity in IDLE must not disturb the held result
      m_out  = 2'b11;
      m_done = 2'b11;
      @(posedge clk); #1;
      check($sformatf("v%0d_valid_width", i), int'(m_sum_valid), 0);
      check($sformatf("v%0d_fire_low", i), int'(m_fire), 0);
      repeat (2) @(posedge clk);
      #1;
      check($sformatf("v%0d_sum_hold", i), int'(m_sum), vecs[i].exp_sum);
      m_out  = '0;
      m_done = '0;
    end

    // Asynchronous reset in the middle of ACCUM
    m_issue_start(0);
    m_out = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    check("rst_pre_sum", int'(m_sum), 6);
    #2 reset_n = 1'b0;
    #1;
    check("rst_sum", int'(m_sum), 0);
    check("rst_busy", int'(m_busy), 0);
    check("rst_valid", int'(m_sum_valid), 0);
    $display("txn rst: sum=%0d busy=%0d", m_sum, m_busy);
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_done  = 2'b11;
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (m_sum_valid) seen++;
    end
    check("rst_no_report", seen, 0);
    check("rst_sum_after", int'(m_sum), 0);
    m_out  = '0;
    m_done = '0;

    // Restart mid-ACCUM after 7 pulses
    m_issue_start(3);
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      m_out[0] = 1'b1;
      m_out[1] = (c < 3);
      @(posedge clk); #1;
      if (m_sum_valid) seen++;
    end
    check("rs_pre_sum", int'(m_sum), 7);
    m_out   = 2'b11;
    m_thr   = 10'd3;
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    if (m_sum_valid) seen++;
    check("rs_no_report", seen, 0);
    check("rs_cleared", int'(m_sum), 0);
    check("rs_busy", int'(m_busy), 1);
    run_body(2, 1, 1, 1, lat);
    $display("txn restart: sum=%0d fire=%0d latency=%0d", m_sum, m_fire, lat);
    check("rs_lat", lat, 1);
    check("rs_sum", int'(m_sum), 3);
    check("rs_fire", int'(m_fire), 1);
    @(posedge clk); #1;

    // Start during REPORT: report completes, ACCUM restarts next cycle
    m_issue_start(0);
    run_body(1, 0, 1, 0, lat);
    check("b2b_first_lat", lat, 0);
    check("b2b_first_sum", int'(m_sum), 2);
    m_thr   = 10'd4;
    m_start = 1'b1;
    @(posedge clk); #1;
    m_start = 1'b0;
    check("b2b_busy", int'(m_busy), 1);
    check("b2b_cleared", int'(m_sum), 0);
    check("b2b_valid_low", int'(m_sum_valid), 0);
    run_body(2, 2, 2, 2, lat);
    $display("txn b2b: sum=%0d fire=%0d latency=%0d", m_sum, m_fire, lat);
    check("b2b_lat", lat, 2);
    check("b2b_sum", int'(m_sum), 4);
    check("b2b_fire", int'(m_fire), 1);
    @(posedge clk); #1;

    // Narrow instance: no timeout when disabled, then saturation
    s_thr   = 4'd0;
    s_start = 1'b1;
    @(posedge clk); #1;
    s_start = 1'b0;
    s_done  = 4'b0111;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (s_sum_valid) seen++;
    end
    check("sat_no_timeout", seen, 0);
    check("sat_still_busy", int'(s_busy), 1);
    s_thr   = 4'd15;
    s_start = 1'b1;
    s_done  = 4'b0000;
    @(posedge clk); #1;
    s_start = 1'b0;
    lat = -1;
    for (int c = 0; c < 40; c++) begin
      s_out  = (c < 5) ? 4'b1111 : 4'b0000;
      s_done = (c >= 4) ? 4'b1111 : 4'b0000;
      @(posedge clk); #1;
      if (s_sum_valid) begin
        lat = c;
        break;
      end
    end
    $display("txn sat: sum=%0d fire=%0d timed_out=%0d latency=%0d", s_sum, s_fire, s_timed_out, lat);
    check("sat_lat", lat, 4);
    check("sat_sum", int'(s_sum), 15);
    check("sat_fire", int'(s_fire), 1);
    check("sat_to", int'(s_timed_out), 0);
    s_out  = '0;
    s_done = '0;
    @(posedge clk); #1;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
